// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
//   Bundles the requester side and the FIFO write side of fifo_wr_arbiter.
//   slave  : the arbiter (drives req_ready and the FIFO write strobe/data).
//   master : the surroundings (requesters drive valid/data, the FIFO drives full).
// Signals:
//   req_valid [NUM_REQ]     per-requester byte valid
//   req_data  [8*NUM_REQ]   requester i on bits [8i+7:8i]
//   req_ready [NUM_REQ]     one-hot accept strobe
//   fifo_full               registered FIFO full flag
//   fifo_wr_en / fifo_din   registered FIFO write port
//   grant_id  [ID_W]        last granted requester
//   busy                    arbiter not idle
//   wr_count  [16*NUM_REQ]  per-requester write counters (only with FIFO_ARB_STATS_EN)
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 fifo_full;
    logic                 fifo_wr_en;
    logic [7:0]           fifo_din;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
`ifdef FIFO_ARB_STATS_EN
    logic [16*NUM_REQ-1:0] wr_count;

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_din, grant_id, busy, wr_count
    );
    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_din, grant_id, busy, wr_count
    );
`else
    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_din, grant_id, busy
    );
    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
    );
`endif
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the 8-bit write port of the dual-clock FIFO between NUM_REQ
//   requesters in the write-clock domain. Round-robin with a bounded burst
//   (MAX_BURST consecutive grants) per requester. Every write is followed by a
//   settle cycle so the registered FIFO full flag is never read stale:
//   IDLE (accept) -> WRITE (wr_en) -> SETTLE -> IDLE, i.e. 1 byte / 3 clk peak.
// Ports:
//   clk   FIFO write clock
//   rst   synchronous active-high reset (shared with the FIFO)
//   bus   fifo_wr_arbiter_if.slave (requester handshake + FIFO write side)
// Optional: define FIFO_ARB_STATS_EN to add per-requester saturating write
//   counters on bus.wr_count (16 bits per requester).
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [ID_W-1:0]   rr_ptr;      // previous winner; scan starts just above it
    logic [3:0]        burst_cnt;   // 0 means nobody currently holds a burst
    logic [ID_W-1:0]   grant_id_q;
    logic              wr_en_q;
    logic [7:0]        din_q;

    logic              accept;
    logic              hold;
    logic [ID_W-1:0]   win_id;
    logic [7:0]        win_data;
    logic [NUM_REQ-1:0] ready;

    // Winner selection and next state.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        ready    = '0;
        hold     = (burst_cnt != 4'd0) && (burst_cnt < 4'(MAX_BURST)) && bus.req_valid[rr_ptr];
        win_id   = rr_ptr;
        if (!hold) begin
            // Descending walk so the nearest valid index above rr_ptr is the
            // last assignment; distance NUM_REQ is rr_ptr itself (sole requester).
            for (int i = NUM_REQ; i >= 1; i--) begin
                if (bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ])
                    win_id = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
        win_data = bus.req_data[8*int'(win_id) +: 8];

        case (state)
            IDLE: begin
                if (!bus.fifo_full && (|bus.req_valid)) begin
                    accept        = 1'b1;
                    ready[win_id] = 1'b1;
                    state_nx      = WRITE;
                end
            end
            WRITE:   state_nx = SETTLE;
            SETTLE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= ID_W'(NUM_REQ - 1);
            burst_cnt  <= 4'd0;
            grant_id_q <= '0;
            wr_en_q    <= 1'b0;
            din_q      <= 8'd0;
        end else begin
            state   <= state_nx;
            wr_en_q <= accept;
            if (accept) begin
                din_q      <= win_data;
                rr_ptr     <= win_id;
                grant_id_q <= win_id;
                burst_cnt  <= hold ? burst_cnt + 4'd1 : 4'd1;
            end else if (state == IDLE && !bus.fifo_full && !bus.req_valid[rr_ptr]) begin
                // Holder let go while the FIFO could have taken a byte.
                burst_cnt <= 4'd0;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.fifo_wr_en = wr_en_q;
    assign bus.fifo_din   = din_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = (state != IDLE);

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] wr_cnt;

    // grant_id_q names the owner of the byte on the bus during WRITE.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [15:0] cnt;
        always_ff @(posedge clk) begin
            if (rst)
                cnt <= 16'd0;
            else if (state == WRITE && grant_id_q == ID_W'(g) && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
        assign wr_cnt[g] = cnt;
    end

    assign bus.wr_count = wr_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Scoreboarded bench for fifo_wr_arbiter: a reference model predicts each
//   accept and pushes the expected byte/id, popped when fifo_wr_en appears.
//   Stimulus phases also push expected grant orders into rr_q.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;
    localparam int MAX_BURST = 4;

    typedef struct {
        logic [7:0] data;
        int         id;
    } sb_t;

    logic clk;
    logic rst;
    logic [NUM_REQ-1:0][7:0] req_bytes;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.req_data = req_bytes;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_chk  = 0;
    int  n_fail = 0;
    sb_t sb_q[$];
    int  rr_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit   started = 0;
    int   m_phase;              // 0 idle, 1 write, 2 settle
    int   m_ptr;
    int   m_cnt;
    bit   prev_wr;
    int   w;
    bit   m_hold;
    logic [NUM_REQ-1:0] exp_rdy;
    sb_t  e;
    int   exp_id;

    always @(negedge clk) begin
        if (!started) begin
            if (rst) started = 1;
            m_phase = 0; m_ptr = NUM_REQ - 1; m_cnt = 0; prev_wr = 0;
        end else begin
            chk("busy", bus.busy, m_phase != 0);
            chk("wr_en", bus.fifo_wr_en, m_phase == 1);
            chk("no_b2b_wr", bus.fifo_wr_en & prev_wr, 1'b0);
            prev_wr = bus.fifo_wr_en;
            if (bus.fifo_wr_en) begin
                chk("sb_nonempty", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("fifo_din", bus.fifo_din, e.data);
                    chk("grant_id", bus.grant_id, e.id);
                end
            end

            exp_rdy = '0;
            case (m_phase)
                0: begin
                    if (!bus.fifo_full) begin
                        if (|bus.req_valid) begin
                            m_hold = (m_cnt > 0) && (m_cnt < MAX_BURST) && bus.req_valid[m_ptr];
                            if (m_hold) begin
                                w = m_ptr;
                                m_cnt++;
                            end else begin
                                w = -1;
                                for (int k = 1; k <= NUM_REQ; k++)
                                    if (w < 0 && bus.req_valid[(m_ptr + k) % NUM_REQ])
                                        w = (m_ptr + k) % NUM_REQ;
                                m_cnt = 1;
                            end
                            exp_rdy[w] = 1'b1;
                            e.data = req_bytes[w];
                            e.id   = w;
                            sb_q.push_back(e);
                            if (rr_q.size() != 0) begin
                                exp_id = rr_q.pop_front();
                                chk("rr_order", bus.req_ready, NUM_REQ'(1) << exp_id);
                            end
                            m_ptr   = w;
                            m_phase = 1;
                        end else if (!bus.req_valid[m_ptr]) begin
                            m_cnt = 0;
                        end
                    end
                end
                1: m_phase = 2;
                default: m_phase = 0;
            endcase
            chk("req_ready", bus.req_ready, exp_rdy);

            if (rst) begin
                m_phase = 0; m_ptr = NUM_REQ - 1; m_cnt = 0; prev_wr = 0;
                sb_q.delete();
            end
        end
    end

    // Wait for n accepts, then return just after the following edge (WRITE cycle).
    task automatic run_until_accepts(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 300) begin
            @(negedge clk);
            if (|bus.req_ready) got++;
            cyc++;
        end
        chk("accept_cnt", got, n);
        @(posedge clk); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.fifo_full = 1'b0;
        req_bytes     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_wr_en", bus.fifo_wr_en, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_din", bus.fifo_din, 0);
        cycles(3);

        // Single requester, crosses burst saturation (re-grant to itself)
        req_bytes[1]  = 8'hA5;
        bus.req_valid = 4'b0010;
        run_until_accepts(6);
        bus.req_valid = '0;
        cycles(3);
        chk("single_grant_id", bus.grant_id, 1);

        // Round-robin with bursts from a fresh reset
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) req_bytes[i] = 8'hC0 + 8'(i);
        for (int k = 0; k < 18; k++) rr_q.push_back((k / MAX_BURST) % NUM_REQ);
        bus.req_valid = '1;
        run_until_accepts(18);
        bus.req_valid = '0;
        cycles(3);

        // Full stall: nothing accepted while full, order resumes after
        req_bytes[2]  = 8'h5A;
        req_bytes[3]  = 8'h3C;
        bus.fifo_full = 1'b1;
        bus.req_valid = 4'b1100;
        cycles(8);
        chk("stall_busy", bus.busy, 1'b0);
        rr_q.push_back(2); rr_q.push_back(2); rr_q.push_back(2);
        rr_q.push_back(2); rr_q.push_back(3);
        bus.fifo_full = 1'b0;
        run_until_accepts(5);
        bus.req_valid = '0;
        cycles(3);

        // Reset during WRITE
        for (int i = 0; i < NUM_REQ; i++) req_bytes[i] = 8'h90 + 8'(i);
        bus.req_valid = '1;
        run_until_accepts(1);
        rst = 1'b1;
        rr_q.push_back(0);
        cycles(1);
        rst = 1'b0;
        chk("midrst_wr_en", bus.fifo_wr_en, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        run_until_accepts(1);
        bus.req_valid = '0;
        cycles(3);

`ifdef FIFO_ARB_STATS_EN
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        req_bytes[0]  = 8'h11;
        req_bytes[2]  = 8'h22;
        bus.req_valid = 4'b0001;
        run_until_accepts(5);
        bus.req_valid = '0;
        cycles(3);
        bus.req_valid = 4'b0100;
        run_until_accepts(3);
        bus.req_valid = '0;
        cycles(4);
        chk("wr_count0", bus.wr_count[15:0], 5);
        chk("wr_count1", bus.wr_count[31:16], 0);
        chk("wr_count2", bus.wr_count[47:32], 3);
        chk("wr_count3", bus.wr_count[63:48], 0);
`endif

        cycles(4);
        chk("sb_empty", sb_q.size(), 0);
        chk("rr_q_empty", rr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
